// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter and its lane-alignment helper.
//   arb_state_e : arbiter FSM states
//   size_e      : access size codes carried with a data request
//   owner_e     : which requester owns the transaction in flight
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Byte-enable pattern for an access of the given size, starting at lane 0.
    function automatic logic [7:0] size_byte_mask(input size_e size);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Combinational byte-lane alignment between a right-justified requester view
// and the 64-bit memory bus.
//   byte_off      : address bits [2:0] of the access
//   size          : access size code
//   wdata         : right-justified store data
//   rdata         : raw memory read data
//   wstrb         : byte strobes placed on the addressed lanes (upper lanes
//                   of a crossing access fall off the top)
//   wdata_aligned : store data shifted onto the addressed lanes
//   rdata_aligned : read data shifted down to bit 0 and masked to the size
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  byte_off,
    input  size_e       size,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata_aligned,
    output logic [63:0] rdata_aligned
);

    logic [7:0]  size_mask;
    logic [63:0] rdata_shifted;
    logic [63:0] rdata_mask;

    assign size_mask     = size_byte_mask(size);
    assign wstrb         = size_mask << byte_off;
    assign wdata_aligned = wdata << {byte_off, 3'b000};
    assign rdata_shifted = rdata >> {byte_off, 3'b000};

    always_comb begin
        rdata_mask = '0;
        for (int i = 0; i < 8; i++) begin
            rdata_mask[8*i +: 8] = {8{size_mask[i]}};
        end
    end

    assign rdata_aligned = rdata_shifted & rdata_mask;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single 64-bit memory port between instruction fetch and the
// ID-stage data request. One transaction is outstanding at a time; data wins
// unless fetch has lost STARVE_LIMIT grants in a row.
//
// State table
//   ST_IDLE | no transaction; grant decided combinationally from the requests
//   ST_REQ  | memory request presented with the latched payload
//   ST_RESP | request accepted, waiting for read data / write ack
//
// Ports
//   clk, rst                        : clock, async active-low reset
//   if_req_valid_i/if_addr_i        : fetch request (4-byte aligned address)
//   if_req_ready_o                  : fetch accepted this cycle
//   if_resp_valid_o/if_rdata_o      : fetch response pulse and instruction word
//   d_req_valid_i/d_wen_i/d_addr_i/
//   d_wdata_i/d_wlen_i              : data request (right-justified store data)
//   d_req_ready_o                   : data request accepted this cycle
//   d_resp_valid_o/d_rdata_o        : load data / store ack pulse, load data
//   mem_req_*/mem_resp_*            : memory port
//   busy_o                          : transaction in flight
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_req_ready_o,
    output logic              if_resp_valid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              d_req_valid_i,
    input  logic              d_wen_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [1:0]        d_wlen_i,
    output logic              d_req_ready_o,
    output logic              d_resp_valid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [7:0]        mem_wstrb_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = cnt_t'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    owner_e            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    size_e             size_q;
    logic [DATA_W-1:0] wdata_q;
    cnt_t              starve_q;

    logic              if_resp_valid_q, d_resp_valid_q;
    logic [31:0]       if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              grant_if, grant_d, resp_fire;
    logic [7:0]        lane_wstrb;
    logic [DATA_W-1:0] lane_wdata, lane_rdata;

    mem_lane_align u_lane_align (
        .byte_off      (addr_q[2:0]),
        .size          (size_q),
        .wdata         (wdata_q),
        .rdata         (mem_rdata_i),
        .wstrb         (lane_wstrb),
        .wdata_aligned (lane_wdata),
        .rdata_aligned (lane_rdata)
    );

    always_comb begin
        state_d   = state_q;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        resp_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant_if = if_req_valid_i & (~d_req_valid_i | (starve_q == CNT_MAX));
                grant_d  = d_req_valid_i & ~grant_if;
                if (grant_if | grant_d) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (mem_req_ready_i) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (mem_resp_valid_i) begin
                    resp_fire = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_IF;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            size_q  <= SZ_B;
            wdata_q <= '0;
        end else if (grant_if) begin
            owner_q <= OWN_IF;
            addr_q  <= if_addr_i;
            wen_q   <= 1'b0;
            size_q  <= SZ_W;
            wdata_q <= '0;
        end else if (grant_d) begin
            owner_q <= OWN_D;
            addr_q  <= d_addr_i;
            wen_q   <= d_wen_i;
            size_q  <= size_e'(d_wlen_i);
            wdata_q <= d_wdata_i;
        end
    end

    // Counts data grants that bypassed a waiting fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else if (grant_if) begin
            starve_q <= '0;
        end else if (grant_d && if_req_valid_i && (starve_q != CNT_MAX)) begin
            starve_q <= starve_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_resp_valid_q <= 1'b0;
            d_resp_valid_q  <= 1'b0;
            if_rdata_q      <= '0;
            d_rdata_q       <= '0;
        end else begin
            if_resp_valid_q <= resp_fire && (owner_q == OWN_IF);
            d_resp_valid_q  <= resp_fire && (owner_q == OWN_D);
            if (resp_fire && (owner_q == OWN_IF)) begin
                if_rdata_q <= addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
            end
            if (resp_fire && (owner_q == OWN_D)) begin
                d_rdata_q <= lane_rdata;
            end
        end
    end

    // Readies are held low during reset so every output is quiet while rst=0.
    assign if_req_ready_o  = grant_if & rst;
    assign d_req_ready_o   = grant_d & rst;
    assign if_resp_valid_o = if_resp_valid_q;
    assign d_resp_valid_o  = d_resp_valid_q;
    assign if_rdata_o      = if_rdata_q;
    assign d_rdata_o       = d_rdata_q;

    assign mem_req_valid_o = (state_q == ST_REQ);
    assign mem_wen_o       = wen_q;
    assign mem_addr_o      = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_wdata_o     = lane_wdata;
    assign mem_wstrb_o     = wen_q ? lane_wstrb : 8'h00;
    assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid_i;
    logic [63:0] if_addr_i;
    logic        if_req_ready_o;
    logic        if_resp_valid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_valid_i;
    logic        d_wen_i;
    logic [63:0] d_addr_i;
    logic [63:0] d_wdata_i;
    logic [1:0]  d_wlen_i;
    logic        d_req_ready_o;
    logic        d_resp_valid_o;
    logic [63:0] d_rdata_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic        mem_wen_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_resp_valid_i;
    logic [63:0] mem_rdata_i;
    logic        busy_o;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .ADDR_W(64), .DATA_W(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_req_valid_i   (if_req_valid_i),
        .if_addr_i        (if_addr_i),
        .if_req_ready_o   (if_req_ready_o),
        .if_resp_valid_o  (if_resp_valid_o),
        .if_rdata_o       (if_rdata_o),
        .d_req_valid_i    (d_req_valid_i),
        .d_wen_i          (d_wen_i),
        .d_addr_i         (d_addr_i),
        .d_wdata_i        (d_wdata_i),
        .d_wlen_i         (d_wlen_i),
        .d_req_ready_o    (d_req_ready_o),
        .d_resp_valid_o   (d_resp_valid_o),
        .d_rdata_o        (d_rdata_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_wen_o        (mem_wen_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_wstrb_o      (mem_wstrb_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_rdata_i      (mem_rdata_i),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level reference: one pending transaction, its phase, and
    // the values the response outputs must currently show.
    logic        m_busy, m_sent, m_own_if, m_wen;
    logic [63:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    int          m_starve;
    logic        m_pif, m_pd;
    logic [31:0] m_if_rdata;
    logic [63:0] m_d_rdata;

    logic g_if, g_d, cap_if_ready, cap_d_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_sent = 0; m_own_if = 0; m_wen = 0;
        m_addr = '0; m_wdata = '0; m_size = '0; m_starve = 0;
        m_pif = 0; m_pd = 0; m_if_rdata = '0; m_d_rdata = '0;
    endtask

    // Called at a negedge with inputs already driven: checks outputs, advances
    // the model by one clock, and returns at the following negedge.
    task automatic step();
        logic        gif, gd;
        int          off, nb, s;
        logic [63:0] tmp;
        #1;
        cap_if_ready = if_req_ready_o;
        cap_d_ready  = d_req_ready_o;
        if (!rst) begin
            chk("rst_if_ready", {63'd0, if_req_ready_o}, 64'd0);
            chk("rst_d_ready", {63'd0, d_req_ready_o}, 64'd0);
            chk("rst_if_resp", {63'd0, if_resp_valid_o}, 64'd0);
            chk("rst_d_resp", {63'd0, d_resp_valid_o}, 64'd0);
            chk("rst_if_rdata", {32'd0, if_rdata_o}, 64'd0);
            chk("rst_d_rdata", d_rdata_o, 64'd0);
            chk("rst_mem_valid", {63'd0, mem_req_valid_o}, 64'd0);
            chk("rst_mem_wen", {63'd0, mem_wen_o}, 64'd0);
            chk("rst_mem_addr", mem_addr_o, 64'd0);
            chk("rst_mem_wdata", mem_wdata_o, 64'd0);
            chk("rst_mem_wstrb", {56'd0, mem_wstrb_o}, 64'd0);
            chk("rst_busy", {63'd0, busy_o}, 64'd0);
            model_reset();
            g_if = 0; g_d = 0;
        end else begin
            gif = !m_busy && if_req_valid_i && (!d_req_valid_i || m_starve == STARVE_LIMIT);
            gd  = !m_busy && d_req_valid_i && !gif;
            chk("if_ready", {63'd0, if_req_ready_o}, {63'd0, gif});
            chk("d_ready", {63'd0, d_req_ready_o}, {63'd0, gd});
            chk("busy", {63'd0, busy_o}, {63'd0, m_busy});
            chk("mem_valid", {63'd0, mem_req_valid_o}, {63'd0, m_busy && !m_sent});
            chk("if_resp", {63'd0, if_resp_valid_o}, {63'd0, m_pif});
            chk("d_resp", {63'd0, d_resp_valid_o}, {63'd0, m_pd});
            chk("if_rdata", {32'd0, if_rdata_o}, {32'd0, m_if_rdata});
            chk("d_rdata", d_rdata_o, m_d_rdata);
            off = int'(m_addr[2:0]);
            nb  = 1 << m_size;
            if (m_busy && !m_sent) begin
                s = ((1 << nb) - 1) << off;
                chk("mem_addr", mem_addr_o, m_addr & ~64'h7);
                chk("mem_wen", {63'd0, mem_wen_o}, {63'd0, m_wen});
                chk("mem_wstrb", {56'd0, mem_wstrb_o}, m_wen ? 64'(s & 8'hFF) : 64'd0);
                if (m_wen) chk("mem_wdata", mem_wdata_o, m_wdata << (8 * off));
            end
            g_if = gif; g_d = gd;
            m_pif = 0; m_pd = 0;
            if (gif) begin
                m_busy = 1; m_sent = 0; m_own_if = 1; m_addr = if_addr_i;
                m_wen = 0; m_size = 2'd2; m_wdata = '0; m_starve = 0;
            end else if (gd) begin
                m_busy = 1; m_sent = 0; m_own_if = 0; m_addr = d_addr_i;
                m_wen = d_wen_i; m_size = d_wlen_i; m_wdata = d_wdata_i;
                if (if_req_valid_i && m_starve < STARVE_LIMIT) m_starve++;
            end else if (m_busy && !m_sent) begin
                if (mem_req_ready_i) m_sent = 1;
            end else if (m_busy && mem_resp_valid_i) begin
                m_busy = 0; m_sent = 0;
                if (m_own_if) begin
                    m_pif = 1;
                    m_if_rdata = m_addr[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
                end else begin
                    m_pd = 1;
                    tmp = mem_rdata_i >> (8 * off);
                    if (nb < 8) tmp = tmp & ((64'd1 << (8 * nb)) - 64'd1);
                    m_d_rdata = tmp;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        if_req_valid_i = 0; if_addr_i = '0;
        d_req_valid_i = 0; d_wen_i = 0; d_addr_i = '0; d_wdata_i = '0; d_wlen_i = '0;
        mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        rst = 0;
        step();
        rst = 1;
    endtask

    int exp_seq[6] = '{0, 0, 0, 0, 1, 0};
    int seq[6];
    int ng;

    initial begin
        rst = 0;
        quiet_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // Fetch only
        if_req_valid_i = 1; if_addr_i = 64'h8000_0004;
        step();
        chk("t1_if_ready", {63'd0, cap_if_ready}, 64'd1);
        if_req_valid_i = 0; mem_req_ready_i = 1;
        step();
        chk("t1_mem_addr", mem_addr_o, 64'h8000_0000);
        mem_req_ready_i = 0; mem_resp_valid_i = 1; mem_rdata_i = 64'h1122_3344_5566_7788;
        step();
        chk("t1_if_resp", {63'd0, if_resp_valid_o}, 64'd1);
        chk("t1_if_rdata", {32'd0, if_rdata_o}, 64'h1122_3344);
        mem_resp_valid_i = 0;
        step();
        chk("t1_if_resp_end", {63'd0, if_resp_valid_o}, 64'd0);

        // Store byte
        d_req_valid_i = 1; d_wen_i = 1; d_addr_i = 64'h1003; d_wlen_i = 2'd0; d_wdata_i = 64'hAB;
        step();
        d_req_valid_i = 0;
        chk("t2_wstrb", {56'd0, mem_wstrb_o}, 64'h08);
        chk("t2_wdata", mem_wdata_o, 64'hAB00_0000);
        chk("t2_addr", mem_addr_o, 64'h1000);
        mem_req_ready_i = 1;
        step();
        mem_req_ready_i = 0; mem_resp_valid_i = 1;
        step();
        chk("t2_d_resp", {63'd0, d_resp_valid_o}, 64'd1);
        mem_resp_valid_i = 0;
        step();

        // Load half
        d_req_valid_i = 1; d_wen_i = 0; d_addr_i = 64'h2006; d_wlen_i = 2'd1;
        step();
        d_req_valid_i = 0;
        chk("t3_wstrb", {56'd0, mem_wstrb_o}, 64'h0);
        mem_req_ready_i = 1;
        step();
        mem_req_ready_i = 0; mem_resp_valid_i = 1; mem_rdata_i = 64'hBEEF_0000_0000_0000;
        step();
        chk("t3_d_resp", {63'd0, d_resp_valid_o}, 64'd1);
        chk("t3_d_rdata", d_rdata_o, 64'h0000_0000_0000_BEEF);
        mem_resp_valid_i = 0;
        step();

        // Contention with continuous requests on both sides
        do_reset();
        if_req_valid_i = 1; if_addr_i = 64'h100;
        d_req_valid_i = 1; d_wen_i = 0; d_addr_i = 64'h200; d_wlen_i = 2'd3;
        mem_req_ready_i = 1; mem_resp_valid_i = 1;
        for (int i = 0; i < 6; i++) seq[i] = -1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            mem_rdata_i = {$urandom, $urandom};
            step();
            if (cap_if_ready) begin seq[ng] = 1; ng++; end
            else if (cap_d_ready) begin seq[ng] = 0; ng++; end
        end
        chk("t4_grant_count", 64'(ng), 64'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("t4_grant_%0d", i), 64'(seq[i]), 64'(exp_seq[i]));
        quiet_inputs();
        step(); step(); step();

        // Backpressure: no second grant while the port is stalled
        do_reset();
        d_req_valid_i = 1; d_wen_i = 1; d_addr_i = 64'h3000; d_wlen_i = 2'd3;
        d_wdata_i = 64'h0123_4567_89AB_CDEF;
        if_req_valid_i = 1; if_addr_i = 64'h4000;
        step();
        d_req_valid_i = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_addr", mem_addr_o, 64'h3000);
            chk("t5_wdata", mem_wdata_o, 64'h0123_4567_89AB_CDEF);
            chk("t5_valid", {63'd0, mem_req_valid_o}, 64'd1);
            chk("t5_no_grant", {63'd0, cap_if_ready}, 64'd0);
        end
        quiet_inputs();

        // Reset while waiting for the response
        do_reset();
        if_req_valid_i = 1; if_addr_i = 64'h40;
        step();
        if_req_valid_i = 0; mem_req_ready_i = 1;
        step();
        mem_req_ready_i = 0;
        rst = 0;
        #1;
        chk("t6_mem_valid", {63'd0, mem_req_valid_o}, 64'd0);
        chk("t6_busy", {63'd0, busy_o}, 64'd0);
        step();
        rst = 1; mem_resp_valid_i = 1; mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        chk("t6_no_pulse", {63'd0, if_resp_valid_o}, 64'd0);
        mem_resp_valid_i = 0;
        step();
        chk("t6_no_pulse2", {63'd0, if_resp_valid_o}, 64'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if (!if_req_valid_i && $urandom_range(2) == 0) begin
                if_req_valid_i = 1;
                if_addr_i = {$urandom, $urandom} & ~64'h3;
            end
            if (!d_req_valid_i && $urandom_range(2) == 0) begin
                d_req_valid_i = 1;
                d_wen_i = 1'($urandom_range(1));
                d_addr_i = {$urandom, $urandom};
                d_wlen_i = 2'($urandom_range(3));
                d_wdata_i = {$urandom, $urandom};
            end
            mem_req_ready_i = ($urandom_range(2) != 0);
            mem_resp_valid_i = ($urandom_range(2) == 0);
            mem_rdata_i = {$urandom, $urandom};
            rst = ($urandom_range(299) != 0);
            step();
            if (g_if) if_req_valid_i = 0;
            if (g_d) d_req_valid_i = 0;
        end
        rst = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single 64-bit memory port between instruction fetch and the ID-stage data request. The ID-stage data request carries valid, wen, addr, wdata and a 2-bit size code.
- Grants one requester at a time; one transaction outstanding.
- Performs byte-lane alignment: write strobes/data shift and read data shift.
- Data side has priority, bounded by an anti-starvation counter for fetch.

Parameters:
STARVE_LIMIT, 4, consecutive data grants made while fetch waits before fetch is forced to win (≥1)
ADDR_W, 64, address width
DATA_W, 64, memory data width (fixed 64; lane logic assumes 8 byte lanes)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req_valid_i  in  1  fetch request; held with stable address until accepted
if_addr_i  in  ADDR_W  fetch address (4-byte aligned)
if_req_ready_o  out  1  fetch request accepted this cycle
if_resp_valid_o  out  1  one-cycle pulse, fetch data valid
if_rdata_o  out  32  instruction word
d_req_valid_i  in  1  data request; held with stable payload until accepted
d_wen_i  in  1  1 = store, 0 = load
d_addr_i  in  ADDR_W  byte address
d_wdata_i  in  64  store data, right-justified
d_wlen_i  in  2  size code: 0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B
d_req_ready_o  out  1  data request accepted this cycle
d_resp_valid_o  out  1  one-cycle pulse: load data valid, or store acknowledged
d_rdata_o  out  64  load data, right-justified, zero-filled (extension done downstream)
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_wen_o  out  1  write
mem_addr_o  out  ADDR_W  address, low 3 bits forced to 0
mem_wdata_o  out  64  lane-aligned write data
mem_wstrb_o  out  8  byte strobes (0 for reads)
mem_resp_valid_i  in  1  read data / write ack
mem_rdata_i  in  64  read data
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst=0): state IDLE, starve_cnt 0. All outputs 0, including mem_req_valid_o, effective immediately. A response arriving after reset is dropped.
- FSM states: IDLE, REQ, RESP.
- IDLE grant:
  - grant_if = if_req_valid_i & (~d_req_valid_i | starve_cnt==STARVE_LIMIT)
  - grant_d = d_req_valid_i & ~grant_if
  - Matching *_req_ready_o is asserted combinationally in IDLE only.
  - On grant: latch owner, addr, wen, size, wdata; go to REQ.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) when grant_d while if_req_valid_i=1.
  - Cleared on grant_if.
  - Otherwise held.
- REQ: mem_req_valid_o=1 with a stable registered payload. On mem_req_ready_i go to RESP. Earliest response is the cycle after acceptance; mem_resp_valid_i in REQ is ignored.
- RESP: wait indefinitely. On mem_resp_valid_i:
  - pulse the owner's resp_valid for 1 cycle (registered, next cycle);
  - go to IDLE.
  - A new grant is allowed in the same cycle the response pulse is visible.
- Minimum latency, request to response pulse: accept (cycle 0) → mem req (cycle 1) → resp in (cycle 2 if ready at cycle 1) → pulse (cycle 3).
- Fetch data: if_rdata_o = addr[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0].
- Load data: d_rdata_o = mem_rdata_i >> (8*addr[2:0]), masked to the size (upper bytes zero).
- Stores:
  - mem_wstrb_o = ((1<<(1<<size))-1) << addr[2:0], truncated to 8 bits (a crossing access drops upper lanes, no error; misalignment is trapped upstream).
  - mem_wdata_o = wdata << (8*addr[2:0]).
- Loads: mem_wstrb_o = 0.
- Stores also wait in RESP for the ack.
- Simultaneous valid requests at reset release follow the same grant rule.
- Response data outputs hold their last value when not pulsing.

Decomposition:
- Shared defines:
  - FSM state encoding (IDLE/REQ/RESP);
  - size codes (SZ_B/H/W/D);
  - owner encoding (OWN_IF/OWN_D).
- Sub-module mem_lane_align, purely combinational: computes strobe, shifted write data, and shifted/masked read data from addr[2:0] and size.

Test Plan:
1. Fetch only: if_addr=0x8000_0004, mem_rdata=0x11223344_55667788, ready at cycle 1 → mem_addr=0x8000_0000, if_resp_valid pulse at cycle 3, if_rdata=0x11223344.
2. Store byte: d_wen=1, addr=0x1003, wlen=0, wdata=0xAB → mem_wstrb=0x08, mem_wdata=0xAB00_0000, mem_addr=0x1000; d_resp pulse after ack.
3. Load half: addr=0x2006, wlen=1, mem_rdata=0xBEEF_0000_0000_0000 → d_rdata=0x0000_0000_0000_BEEF.
4. Contention, STARVE_LIMIT=4: both valid continuously → grants D,D,D,D,IF,D…; starve_cnt 1,2,3,4 then clears to 0.
5. Backpressure: mem_req_ready_i low 5 cycles → mem_req_valid_o and payload stable all 5 cycles; no second grant.
6. Reset mid-RESP: rst=0 while waiting → mem_req_valid_o=0 and busy_o=0 immediately. A later mem_resp_valid_i produces no resp pulse.
